// File: rtl/fifo_rd_dispatch_pkg.sv
// Shared types and sizing helpers for the FIFO read-side dispatcher.
package fifo_rd_dispatch_pkg;

  typedef enum logic [1:0] {
    IDLE,
    POP,
    WAIT,
    PRESENT
  } disp_state_t;

  // Counter must hold BURST_MAX itself, since it is incremented on the final handshake.
  function automatic int burst_cnt_width(input int burst_max);
    return (burst_max < 1) ? 1 : $clog2(burst_max + 1);
  endfunction

endpackage

// File: rtl/fifo_rd_dispatch_rr_arbiter.sv
// Combinational rotate-priority encoder: picks the first requester after last_grant, wrapping.
module rr_arbiter #(
  parameter int NUM_PORTS = 4,
  parameter int IDX_LEN   = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [IDX_LEN-1:0]   last_grant,
  output logic [IDX_LEN-1:0]   grant_idx,
  output logic                 any_req
);

  logic               hi_found;
  logic [IDX_LEN-1:0] hi_idx;
  logic [IDX_LEN-1:0] lo_idx;

  // Descending scan so the lowest index above (or at/below) last_grant is kept.
  always_comb begin
    hi_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int j = NUM_PORTS - 1; j >= 0; j--) begin
      if (req[j]) begin
        if (j > int'(last_grant)) begin
          hi_found = 1'b1;
          hi_idx   = IDX_LEN'(j);
        end else begin
          lo_idx = IDX_LEN'(j);
        end
      end
    end
    grant_idx = hi_found ? hi_idx : lo_idx;
    any_req   = |req;
  end

endmodule

// File: rtl/fifo_rd_dispatch.sv
// Read-domain scheduler sharing one FIFO read port among NUM_PORTS consumers with bounded bursts.
module fifo_rd_dispatch
  import fifo_rd_dispatch_pkg::*;
#(
  parameter int DATA_LEN  = 16,
  parameter int NUM_PORTS = 4,
  parameter int BURST_MAX = 4,
  parameter int IDX_LEN   = $clog2(NUM_PORTS)
) (
  input  logic                 rclk,
  input  logic                 PresetFull,
  output logic                 fifo_rd_en,
  input  logic                 fifo_rd_empty,
  input  logic [DATA_LEN-1:0]  fifo_data,
  input  logic [NUM_PORTS-1:0] cons_req,
  input  logic [NUM_PORTS-1:0] cons_ready,
  output logic [NUM_PORTS-1:0] cons_valid,
  output logic [DATA_LEN-1:0]  cons_data,
  output logic [IDX_LEN-1:0]   grant_idx,
  output logic                 busy
);

  localparam int CNT_LEN = burst_cnt_width(BURST_MAX);

  disp_state_t         state_q, state_d;
  logic [IDX_LEN-1:0]  grant_q, grant_d;
  logic [IDX_LEN-1:0]  last_grant_q, last_grant_d;
  logic [CNT_LEN-1:0]  burst_cnt_q, burst_cnt_d;
  logic [DATA_LEN-1:0] data_q, data_d;
  logic [IDX_LEN-1:0]  arb_idx;
  logic                any_req;

  rr_arbiter #(
    .NUM_PORTS(NUM_PORTS),
    .IDX_LEN  (IDX_LEN)
  ) u_arb (
    .req       (cons_req),
    .last_grant(last_grant_q),
    .grant_idx (arb_idx),
    .any_req   (any_req)
  );

  always_ff @(posedge rclk or posedge PresetFull) begin
    if (PresetFull) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= IDX_LEN'(NUM_PORTS - 1);
      burst_cnt_q  <= '0;
      data_q       <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      burst_cnt_q  <= burst_cnt_d;
      data_q       <= data_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    burst_cnt_d  = burst_cnt_q;
    data_d       = data_q;
    fifo_rd_en   = 1'b0;
    cons_valid   = '0;
    case (state_q)
      IDLE: begin
        if (any_req && !fifo_rd_empty) begin
          grant_d     = arb_idx;
          burst_cnt_d = '0;
          state_d     = POP;
        end
      end
      POP: begin
        if (!fifo_rd_empty) begin
          fifo_rd_en = 1'b1;
          state_d    = WAIT;
        end else begin
          last_grant_d = grant_q;
          state_d      = IDLE;
        end
      end
      WAIT: begin
        data_d  = fifo_data;
        state_d = PRESENT;
      end
      PRESENT: begin
        // The word is held until the granted consumer takes it, regardless of its request.
        cons_valid[grant_q] = 1'b1;
        if (cons_ready[grant_q]) begin
          burst_cnt_d = burst_cnt_q + CNT_LEN'(1);
          if (cons_req[grant_q] && (int'(burst_cnt_q) + 1 < BURST_MAX) && !fifo_rd_empty) begin
            state_d = POP;
          end else begin
            last_grant_d = grant_q;
            state_d      = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign cons_data = data_q;
  assign grant_idx = grant_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_fifo_rd_dispatch.sv
// Directed self-checking bench for fifo_rd_dispatch with a small behavioural FIFO model.
module tb_fifo_rd_dispatch;

  logic        rclk;
  logic        PresetFull;
  logic        fifo_rd_en;
  logic        fifo_rd_empty;
  logic [15:0] fifo_data;
  logic [3:0]  cons_req;
  logic [3:0]  cons_ready;
  logic [3:0]  cons_valid;
  logic [15:0] cons_data;
  logic [1:0]  grant_idx;
  logic        busy;

  int vectors     = 0;
  int miscompares = 0;

  logic [15:0] mem [0:63];
  int          wr_ptr = 0;
  int          rd_ptr = 0;
  logic        force_empty;

  fifo_rd_dispatch #(
    .DATA_LEN (16),
    .NUM_PORTS(4),
    .BURST_MAX(4)
  ) dut (
    .rclk         (rclk),
    .PresetFull   (PresetFull),
    .fifo_rd_en   (fifo_rd_en),
    .fifo_rd_empty(fifo_rd_empty),
    .fifo_data    (fifo_data),
    .cons_req     (cons_req),
    .cons_ready   (cons_ready),
    .cons_valid   (cons_valid),
    .cons_data    (cons_data),
    .grant_idx    (grant_idx),
    .busy         (busy)
  );

  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  // Read data appears one cycle after an accepted pop, as in the real FIFO.
  assign fifo_rd_empty = force_empty || (wr_ptr == rd_ptr);
  always @(posedge rclk) begin
    if (fifo_rd_en && !fifo_rd_empty) begin
      fifo_data <= mem[rd_ptr];
      rd_ptr    <= rd_ptr + 1;
    end
  end

  task automatic tick();
    @(negedge rclk);
  endtask

  task automatic push(input logic [15:0] d);
    mem[wr_ptr] = d;
    wr_ptr      = wr_ptr + 1;
  endtask

  task automatic applyStimulus(input logic [3:0] req, input logic [3:0] ready);
    cons_req   = req;
    cons_ready = ready;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  initial begin
    int          gap;
    logic [3:0]  exp_valid;

    PresetFull  = 1'b1;
    force_empty = 1'b0;
    fifo_data   = '0;
    applyStimulus(4'b0000, 4'b0000);
    #1;
    checkOutput("rst_rd_en", 32'(fifo_rd_en), 32'd0);
    checkOutput("rst_valid", 32'(cons_valid), 32'd0);
    checkOutput("rst_data", 32'(cons_data), 32'd0);
    checkOutput("rst_grant", 32'(grant_idx), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    tick();
    tick();
    PresetFull = 1'b0;

    // All ports requesting, ready held: four-word bursts in port order, 3 cycles per word.
    for (int k = 0; k < 16; k++) push(16'h1000 + 16'(k));
    applyStimulus(4'b1111, 4'b1111);
    gap = 0;
    for (int k = 0; k < 16; k++) begin
      for (int c = 0; c < 10 && cons_valid == 4'b0000; c++) begin
        tick();
        gap++;
      end
      exp_valid = 4'b0001 << (k / 4);
      checkOutput($sformatf("burst_valid_%0d", k), 32'(cons_valid), 32'(exp_valid));
      checkOutput($sformatf("burst_data_%0d", k), 32'(cons_data), 32'h1000 + 32'(k));
      if (k % 4 != 0) checkOutput($sformatf("burst_gap_%0d", k), 32'(gap), 32'd3);
      tick();
      gap = 1;
    end
    applyStimulus(4'b0000, 4'b0000);
    tick();
    checkOutput("burst_end_busy", 32'(busy), 32'd0);

    // Single request on port 0: pop one cycle later, word presented three cycles after request.
    push(16'hA5A5);
    applyStimulus(4'b0001, 4'b0000);
    tick();
    checkOutput("t1_rd_en", 32'(fifo_rd_en), 32'd1);
    checkOutput("t1_grant", 32'(grant_idx), 32'd0);
    checkOutput("t1_busy", 32'(busy), 32'd1);
    tick();
    checkOutput("t1_wait_rd_en", 32'(fifo_rd_en), 32'd0);
    checkOutput("t1_wait_valid", 32'(cons_valid), 32'd0);
    tick();
    checkOutput("t1_valid", 32'(cons_valid), 32'b0001);
    checkOutput("t1_data", 32'(cons_data), 32'hA5A5);
    applyStimulus(4'b0000, 4'b0001);
    tick();
    checkOutput("t1_idle_busy", 32'(busy), 32'd0);
    checkOutput("t1_idle_valid", 32'(cons_valid), 32'd0);
    applyStimulus(4'b0000, 4'b0000);

    // Empty FIFO blocks service; a pushed word then starts it.
    applyStimulus(4'b0010, 4'b0000);
    for (int c = 0; c < 3; c++) begin
      tick();
      checkOutput($sformatf("t3_rd_en_%0d", c), 32'(fifo_rd_en), 32'd0);
      checkOutput($sformatf("t3_busy_%0d", c), 32'(busy), 32'd0);
    end
    push(16'hBEEF);
    tick();
    checkOutput("t3_rd_en", 32'(fifo_rd_en), 32'd1);
    checkOutput("t3_grant", 32'(grant_idx), 32'd1);
    tick();
    tick();
    checkOutput("t3_valid", 32'(cons_valid), 32'b0010);

    // Granted port drops its request and stalls; other ports' ready must not complete the word.
    applyStimulus(4'b0000, 4'b1101);
    for (int c = 0; c < 5; c++) begin
      tick();
      checkOutput($sformatf("t5_valid_%0d", c), 32'(cons_valid), 32'b0010);
      checkOutput($sformatf("t5_data_%0d", c), 32'(cons_data), 32'hBEEF);
    end
    applyStimulus(4'b0000, 4'b0010);
    tick();
    checkOutput("t5_done_valid", 32'(cons_valid), 32'd0);
    checkOutput("t5_done_busy", 32'(busy), 32'd0);
    applyStimulus(4'b0000, 4'b0000);

    // FIFO turns empty while in POP: no pop, back to IDLE without a valid pulse.
    push(16'hC0DE);
    applyStimulus(4'b0100, 4'b0000);
    tick();
    checkOutput("t4_pop_busy", 32'(busy), 32'd1);
    force_empty = 1'b1;
    #1;
    checkOutput("t4_rd_en", 32'(fifo_rd_en), 32'd0);
    tick();
    checkOutput("t4_idle_busy", 32'(busy), 32'd0);
    checkOutput("t4_idle_valid", 32'(cons_valid), 32'd0);
    tick();
    checkOutput("t4_still_valid", 32'(cons_valid), 32'd0);
    force_empty = 1'b0;
    applyStimulus(4'b0000, 4'b0000);
    tick();

    // Reset in PRESENT clears outputs at once; the next grant goes to port 0.
    applyStimulus(4'b1000, 4'b0000);
    tick();
    tick();
    tick();
    checkOutput("t6_valid", 32'(cons_valid), 32'b1000);
    checkOutput("t6_data", 32'(cons_data), 32'hC0DE);
    PresetFull = 1'b1;
    #1;
    checkOutput("t6_rst_valid", 32'(cons_valid), 32'd0);
    checkOutput("t6_rst_data", 32'(cons_data), 32'd0);
    checkOutput("t6_rst_grant", 32'(grant_idx), 32'd0);
    checkOutput("t6_rst_busy", 32'(busy), 32'd0);
    checkOutput("t6_rst_rd_en", 32'(fifo_rd_en), 32'd0);
    push(16'h7777);
    applyStimulus(4'b1111, 4'b0000);
    tick();
    PresetFull = 1'b0;
    tick();
    checkOutput("t6_grant", 32'(grant_idx), 32'd0);
    checkOutput("t6_rd_en", 32'(fifo_rd_en), 32'd1);
    tick();
    tick();
    checkOutput("t6_new_valid", 32'(cons_valid), 32'b0001);
    checkOutput("t6_new_data", 32'(cons_data), 32'h7777);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
